// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle control FSM for the KGP-RISC core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives datapath
// enables, extender mode and ALU operand select. Memory waits are bounded by
// a small counter; an illegal opcode or a memory timeout parks the FSM in a
// sticky FAULT state until reset.
module kgp_multicycle_ctrl #(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_imm,
  output logic             imm_sext,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R  = 3'd0,
    C_ALU_IS = 3'd1,
    C_ALU_IZ = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRZ    = 3'd5,
    C_JUMP   = 3'd6
  } cls_t;

  // Last wait count at which a further low mem_ready cycle means timeout.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  cls_t       cls_q;
  cls_t       cls_dec;
  cls_t       cls_eff;
  logic [3:0] wait_q;
  logic       opc_legal;
  logic       mem_timeout;

  assign opc_legal   = (opcode <= OPC_W'(6));
  assign cls_dec     = cls_t'(opcode[2:0]);
  assign mem_timeout = !mem_ready && (wait_q == WAIT_LAST);
  assign state       = state_q;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_DECODE: state_d = opc_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (cls_q == C_BRZ || cls_q == C_JUMP)        state_d = S_FETCH;
        else if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else                                          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)        state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_WB:     state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched instruction class and memory wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU_R;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM))
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
        wait_q <= wait_q + 4'd1;
    end
  end

  // Output decode. Strobes must coincide with the mem_ready / zero_flag
  // cycle, so outputs are decoded from the registered state plus those inputs.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    alu_src_imm = 1'b0;
    imm_sext    = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    cls_eff     = (state_q == S_DECODE) ? cls_dec : cls_q;
    if ((state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) ||
        (state_q == S_DECODE && opc_legal)) begin
      alu_src_imm = (cls_eff == C_ALU_IS) || (cls_eff == C_ALU_IZ) ||
                    (cls_eff == C_LOAD)   || (cls_eff == C_STORE);
      imm_sext    = (cls_eff != C_ALU_IZ);
    end
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls_q == C_BRZ) begin
          pc_we  = zero_flag;
          pc_src = 2'd1;
        end else if (cls_q == C_JUMP) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_STORE);
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = (cls_q == C_LOAD);
      end
      default: ;
    endcase
    busy  = !(state_q == S_IDLE || state_q == S_FAULT);
    fault = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Scoreboard bench for kgp_multicycle_ctrl: an instruction-level reference
// model emits the expected per-cycle output vector while driving inputs; a
// monitor pops and compares one vector on every falling edge.
module tb_kgp_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_FAULT = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_imm, sext, reg_we, wb_sel, busy, fault;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_imm, imm_sext, reg_we, wb_sel, busy, fault;
  logic [2:0] state;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  kgp_multicycle_ctrl #(.OPC_W(6), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_imm(alu_src_imm), .imm_sext(imm_sext), .reg_we(reg_we),
    .wb_sel(wb_sel), .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e       = '0;
    e.st    = st;
    e.busy  = !(st == ST_IDLE || st == ST_FAULT);
    e.fault = (st == ST_FAULT);
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge, record what the DUT
  // must show for the rest of that cycle.
  task automatic step(input exp_t e, input logic rdy, input logic zf,
                      input logic [5:0] opc, input logic r);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero_flag = zf;
    opcode    = opc;
    rst       = r;
    sb.push_back(e);
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 20; i++)
      step(mk(ST_FAULT), rbit(), rbit(), rop(), i == 19);
    step(mk(ST_IDLE), rbit(), rbit(), rop(), 1'b0);
  endtask

  // fw/mw: low mem_ready cycles before the access completes in FETCH/MEM;
  // rst_mem: index of the MEM wait cycle in which reset is raised (-1: none).
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw,
                           input logic zf, input int rst_mem);
    exp_t e;
    bit   legal, aim, sx;
    int   cls;
    legal = (opc <= 6);
    cls   = int'(opc);
    aim   = legal && cls >= 1 && cls <= 4;
    sx    = legal && cls != 2;
    for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) begin
      e = mk(ST_FETCH); e.mem_req = 1'b1;
      step(e, 1'b0, rbit(), rop(), 1'b0);
    end
    if (fw >= MEM_TIMEOUT) begin fault_tail(); return; end
    e = mk(ST_FETCH); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(e, 1'b1, rbit(), rop(), 1'b0);
    e = mk(ST_DECODE); e.alu_imm = aim; e.sext = sx;
    step(e, rbit(), rbit(), opc, 1'b0);
    if (!legal) begin fault_tail(); return; end
    e = mk(ST_EXEC); e.alu_imm = aim; e.sext = sx;
    if (cls == 5) begin e.pc_we = zf; e.pc_src = 2'd1; end
    if (cls == 6) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
    step(e, rbit(), zf, opc, 1'b0);
    if (cls == 5 || cls == 6) return;
    if (cls == 3 || cls == 4) begin
      for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) begin
        e = mk(ST_MEM); e.mem_req = 1'b1; e.addr_sel = 1'b1;
        e.mem_we = (cls == 4); e.alu_imm = aim; e.sext = sx;
        step(e, 1'b0, rbit(), opc, i == rst_mem);
        if (i == rst_mem) begin
          step(mk(ST_IDLE), rbit(), rbit(), rop(), 1'b0);
          return;
        end
      end
      if (mw >= MEM_TIMEOUT) begin fault_tail(); return; end
      e = mk(ST_MEM); e.mem_req = 1'b1; e.addr_sel = 1'b1;
      e.mem_we = (cls == 4); e.alu_imm = aim; e.sext = sx;
      step(e, 1'b1, rbit(), opc, 1'b0);
      if (cls == 4) return;
    end
    e = mk(ST_WB); e.reg_we = 1'b1; e.wb_sel = (cls == 3);
    e.alu_imm = aim; e.sext = sx;
    step(e, rbit(), rbit(), opc, 1'b0);
  endtask

  // Monitor: compare every cycle that has an expected vector queued.
  initial begin
    exp_t e, a;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{st: state, mem_req: mem_req, mem_we: mem_we, addr_sel: addr_sel,
              ir_we: ir_we, pc_we: pc_we, pc_src: pc_src, alu_imm: alu_src_imm,
              sext: imm_sext, reg_we: reg_we, wb_sel: wb_sel, busy: busy,
              fault: fault};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d state got=%0d want=%0d vec got=%b want=%b",
                   cyc, a.st, e.st, a, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] opc;
    int         fw, mw, rm, r;
    // Reset held for one sampled edge, then released while in IDLE.
    step(mk(ST_IDLE), 1'b0, 1'b0, 6'd0, 1'b1);
    step(mk(ST_IDLE), 1'b0, 1'b0, 6'd0, 1'b0);
    // Directed cases.
    run_instr(6'd0, 0, 0, 1'b0, -1);            // R-type ALU
    run_instr(6'd1, 0, 0, 1'b0, -1);            // addi: sign-extend
    run_instr(6'd2, 0, 0, 1'b0, -1);            // andi/ori: zero-extend
    run_instr(6'd3, 0, 3, 1'b0, -1);            // load, 3 wait states
    run_instr(6'd5, 0, 0, 1'b1, -1);            // branch taken
    run_instr(6'd5, 0, 0, 1'b0, -1);            // branch not taken
    run_instr(6'd6, 1, 0, 1'b0, -1);            // jump
    run_instr(6'd4, 0, 2, 1'b0, -1);            // store
    run_instr(6'd3, 14, 14, 1'b0, -1);          // success on the last allowed cycle
    run_instr(6'd9, 0, 0, 1'b0, -1);            // illegal opcode
    run_instr(6'd0, 15, 0, 1'b0, -1);           // fetch timeout
    run_instr(6'd4, 0, 15, 1'b0, -1);           // store data timeout
    run_instr(6'd4, 0, 3, 1'b0, 1);             // reset during store MEM
    run_instr(6'd0, 0, 0, 1'b0, -1);
    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      opc = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(7, 63))
                                         : 6'($urandom_range(0, 6));
      r  = $urandom_range(0, 29);
      fw = (r == 0) ? 15 : (r == 1) ? 14 : $urandom_range(0, 3);
      r  = $urandom_range(0, 29);
      mw = (r == 0) ? 15 : (r == 1) ? 14 : $urandom_range(0, 3);
      rm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
      run_instr(opc, fw, mw, rbit(), rm);
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kgp_multicycle_ctrl.md
Name: kgp_multicycle_ctrl

Overview:
Multi-cycle control FSM for the KGP-RISC core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the register-file, PC, instruction-register and memory enables, and configures the 16-to-32-bit immediate extender (sign or zero extension) and the ALU operand mux. It sits between the instruction register and the shared datapath (ALU, extender, register file, unified memory port).

Parameters:
- OPC_W, 6, opcode field width
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before a fault

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  OPC_W  IR[31:26], valid from DECODE onward
- zero_flag  in  1  ALU zero result, valid in EXEC
- mem_ready  in  1  memory handshake; access completes in the cycle it is high
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1=write, qualified by mem_req
- addr_sel  out  1  0=PC address (fetch), 1=ALU result (data)
- ir_we  out  1  load instruction register
- pc_we  out  1  PC update strobe
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
- alu_src_imm  out  1  ALU operand B: 0=register, 1=extended immediate
- imm_sext  out  1  extender mode: 1=sign-extend imm16, 0=zero-extend
- reg_we  out  1  register-file write strobe
- wb_sel  out  1  0=ALU result, 1=memory data
- busy  out  1  high in every state except IDLE/FAULT
- fault  out  1  sticky: illegal opcode or memory timeout
- state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE; every output 0. A reset mid-instruction abandons it: no reg_we/pc_we/mem_req in the following cycle. Reset also clears fault.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- IDLE → FETCH on the first cycle after reset deasserts.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0 (single-cycle pulses in that cycle), then → DECODE.
- DECODE: one cycle.
  - Opcode classes: 0 R-type ALU; 1 ALU-imm signed (addi); 2 ALU-imm logical (andi/ori, zero-extend); 3 load; 4 store; 5 branch-if-zero; 6 jump.
  - Any other opcode → FAULT.
  - Otherwise → EXEC.
- EXEC: one cycle.
  - alu_src_imm=1 for classes 1–4; imm_sext=0 only for class 2, 1 otherwise. Both are held stable from DECODE through WB of the same instruction.
  - Class 5: pc_we=zero_flag, pc_src=1, then → FETCH.
  - Class 6: pc_we=1, pc_src=2, then → FETCH.
  - Classes 3/4 → MEM; classes 0–2 → WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for store only.
  - On mem_ready: store → FETCH; load → WB.
- WB: reg_we=1 for one cycle; wb_sel=1 for load, else 0; then → FETCH.
- Memory timeout:
  - A 4-bit wait counter is cleared on entry to FETCH/MEM and increments each cycle mem_ready is low.
  - Reaching MEM_TIMEOUT → FAULT, mem_req dropped the same cycle.
  - mem_ready in the same cycle the count hits the limit counts as success.
- FAULT: fault=1 and busy=0; all strobes 0; stays until rst.
- Strobes (ir_we, pc_we, reg_we) are never high for more than one cycle per instruction.
- mem_req never deasserts before mem_ready except on timeout or reset.
- Latencies with zero wait states:
  - ALU ops: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump: 3 cycles.

Test Plan:
- Reset, then fetch of opcode 0 with mem_ready tied high → state sequence 0,1,2,3,5,1; reg_we high in exactly one cycle; wb_sel=0; alu_src_imm=0.
- Opcode 1 vs opcode 2 → imm_sext=1 for opcode 1 and 0 for opcode 2, alu_src_imm=1 from DECODE to WB.
- Load with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles, mem_we=0, then WB with wb_sel=1; total 8 cycles.
- Branch with zero_flag=1 → pc_we=1, pc_src=1 in EXEC. With zero_flag=0 → pc_we stays 0 and the FSM returns to FETCH.
- Fault cases:
  - Opcode 9 → FAULT after DECODE; fault=1, busy=0 held for 20 cycles.
  - mem_ready held low in FETCH → FAULT after 15 cycles.
- rst asserted during MEM of a store → next cycle state=0, mem_req=0, no mem_we. Normal fetch resumes after rst drops.
